// File: rtl/score_display_if.sv
// Display-side bundle of score_display: the binary score going in and the
// multiplexed 7-segment drive coming out.
// master: the side that supplies the score and watches the display pins.
// slave:  the score_display block itself.
`timescale 1ns/1ps
interface score_display_if;
  logic [15:0] score;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;

  modport master (
    output score,
    input  seg,
    input  dp,
    input  an,
    input  busy
  );

  modport slave (
    input  score,
    output seg,
    output dp,
    output an,
    output busy
  );
endinterface

// File: rtl/score_display.sv
// score_display: converts the 16-bit game score to BCD with a sequential
// double-dabble engine (one shift per clock), then scans the four BCD digits
// onto a common-anode 7-segment display. Scores above MAX_SHOW saturate and
// light the decimal point on every digit as an overflow flag.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (the ones digit is always shown). Without it the display is zero padded.
`timescale 1ns/1ps
module score_display #(
  parameter int SCAN_DIV = 100_000,
  parameter int MAX_SHOW = 9999
) (
  input  logic            clk,
  input  logic            reset,
  score_display_if.slave  sd
);

  localparam int          CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [15:0] MAX_V = 16'(MAX_SHOW);
  localparam logic [4:0]  LAST_ITER = 5'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Clamp a raw score to the largest value the four digits can show.
  function automatic logic [15:0] sat_show(input logic [15:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decade.
  function automatic logic [15:0] bcd_adj(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low gfedcba segment pattern; non-decimal nibbles go dark.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_t      state, state_nxt;
  logic        start;
  logic [15:0] last_val;
  logic [15:0] disp_bcd;
  logic        ovf;

  // Conversion working registers (data only, reloaded at every start).
  logic [15:0] bin_sr;
  logic [15:0] bcd_acc;
  logic [4:0]  iter;
  logic        ovf_pend;
  logic [15:0] acc_adj;
  logic [31:0] shift_val;

  // Scan side.
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       dig_idx;
  logic [3:0]       cur_nib;
  logic             blank;

  // ---------------------------------------------------------------------
  // Converter control: IDLE waits for a new score, SHIFT runs 16 dabble
  // steps, DONE publishes the result in a single update.
  // ---------------------------------------------------------------------

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the conversion start strobe.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (sd.score != last_val) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (iter == LAST_ITER) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One dabble step: correct the BCD nibbles, then shift the pair left.
  always_comb begin
    acc_adj   = bcd_adj(bcd_acc);
    shift_val = {acc_adj, bin_sr} << 1;
  end

  // Control registers: latched score, published BCD, overflow flag, busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_val <= 16'h0000;
      disp_bcd <= 16'h0000;
      ovf      <= 1'b0;
      sd.busy  <= 1'b0;
    end else if (start) begin
      last_val <= sd.score;
      sd.busy  <= 1'b1;
    end else if (state == DONE) begin
      disp_bcd <= bcd_acc;
      ovf      <= ovf_pend;
      sd.busy  <= 1'b0;
    end
  end

  // Shift engine datapath; a partial result is simply never published.
  always_ff @(posedge clk) begin
    if (start) begin
      bin_sr   <= sat_show(sd.score);
      bcd_acc  <= 16'h0000;
      iter     <= 5'd0;
      ovf_pend <= (sd.score > MAX_V);
    end else if (state == SHIFT) begin
      bcd_acc  <= shift_val[31:16];
      bin_sr   <= shift_val[15:0];
      iter     <= iter + 5'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Display scan: each digit is lit for SCAN_DIV cycles in turn; the pin
  // registers trail dig_idx/disp_bcd by one clock.
  // ---------------------------------------------------------------------

  always_comb begin
    cur_nib = disp_bcd[{dig_idx, 2'b00} +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit goes dark when it and every more-significant digit are zero;
  // the ones digit always shows so a zero score reads "0".
  always_comb begin
    blank = 1'b0;
    case (dig_idx)
      2'd3:    blank = (disp_bcd[15:12] == 4'h0);
      2'd2:    blank = (disp_bcd[15:8]  == 8'h00);
      2'd1:    blank = (disp_bcd[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  // All four digits are always driven, zero padded.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Scan counter, digit select and registered display pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      sd.an    <= 4'b1111;
      sd.seg   <= 7'h7F;
      sd.dp    <= 1'b1;
    end else begin
      if (scan_cnt == CNT_LAST) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blank) begin
        sd.an  <= 4'b1111;
        sd.seg <= 7'h7F;
        sd.dp  <= 1'b1;
      end else begin
        sd.an  <= ~(4'b0001 << dig_idx);
        sd.seg <= seg_enc(cur_nib);
        sd.dp  <= ~ovf;
      end
    end
  end

endmodule
